bp_cache_req_event_buffer: RTL and testbench

Synthesizable capture stage between an L1 cache's request/completion interface and the cache trace sink. Taps the cache request valid, message type and address, plus the completion strobe from the cache engine. Timestamps each request and measures its miss latency in cycles. Buffers finished records in a small FIFO that the nonsynth cache tracer, or a debug port, drains with a valid/ready handshake.

---
 rtl/bp_cache_req_event_buffer.sv | 245 ++++++++++++++++++++++++
 tb/tb_bp_cache_req_event_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cache_req_event_buffer.sv
// bp_cache_req_event_buffer
//
// Sits between an L1 cache request/completion interface and the cache
// trace sink. Each blocking request is stamped with the free-running cycle
// counter, and the stage counts how many cycles pass until the cache engine
// signals completion. Posted requests expect no completion, so they are
// recorded immediately with zero latency. Finished records go into a small
// flop-based FIFO. A valid/ready handshake drains that FIFO.
//
// Configuration macro: BP_CACHE_EVT_OVERWRITE_EN
//   defined   - a push into a full FIFO with no pop evicts the oldest record
//   undefined - a push into a full FIFO with no pop discards the new record
//   In both cases drop_count_o increments.
//
// Ports
//   clk_i           clock
//   reset_n_i       synchronous active-low reset
//   freeze_i        core frozen: abandons any pending capture, blocks new ones
//   req_v_i         cache request valid
//   req_msg_type_i  request message type, recorded verbatim
//   req_addr_i      request address
//   req_posted_i    request expects no completion
//   req_complete_i  completion strobe from the cache engine
//   evt_v_o         record valid at FIFO head
//   evt_ready_i     sink accepts the head record
//   evt_addr_o      head record address
//   evt_msg_type_o  head record message type
//   evt_start_o     head record request cycle stamp
//   evt_latency_o   head record latency, saturating
//   outstanding_o   blocking request in flight (registered)
//   drop_count_o    records lost, saturating
//   err_o           sticky protocol violation

module bp_cache_req_event_buffer #(
   parameter int paddr_width_p    = 40,
   parameter int msg_type_width_p = 4,
   parameter int cycle_width_p    = 32,
   parameter int latency_width_p  = 16,
   parameter int els_p            = 8
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        freeze_i,
   input  logic                        req_v_i,
   input  logic [msg_type_width_p-1:0] req_msg_type_i,
   input  logic [paddr_width_p-1:0]    req_addr_i,
   input  logic                        req_posted_i,
   input  logic                        req_complete_i,
   output logic                        evt_v_o,
   input  logic                        evt_ready_i,
   output logic [paddr_width_p-1:0]    evt_addr_o,
   output logic [msg_type_width_p-1:0] evt_msg_type_o,
   output logic [cycle_width_p-1:0]    evt_start_o,
   output logic [latency_width_p-1:0]  evt_latency_o,
   output logic                        outstanding_o,
   output logic [15:0]                 drop_count_o,
   output logic                        err_o
);

   localparam int idx_w_lp = $clog2(els_p);
   localparam int rec_w_lp = paddr_width_p + msg_type_width_p + cycle_width_p + latency_width_p;

   typedef enum logic [0:0] {
      e_idle    = 1'b0,
      e_pending = 1'b1
   } state_e;

   // Saturating +1 used for the latency field
   function automatic logic [latency_width_p-1:0] lat_sat_inc(input logic [latency_width_p-1:0] v);
      logic [latency_width_p-1:0] r;
      if (v == {latency_width_p{1'b1}}) begin
         r = v;
      end else begin
         r = v + latency_width_p'(1);
      end
      return r;
   endfunction

   state_e                      state_r, state_n_s;
   logic [cycle_width_p-1:0]    cycle_r;
   logic [paddr_width_p-1:0]    addr_r;
   logic [msg_type_width_p-1:0] type_r;
   logic [cycle_width_p-1:0]    start_r;
   logic [latency_width_p-1:0]  lat_r;
   logic                        outstanding_r;
   logic                        err_r;
   logic [15:0]                 drop_r;

   logic [rec_w_lp-1:0]         mem_r [els_p];
   logic [idx_w_lp:0]           wptr_r, rptr_r;

   logic                        cap_s;
   logic                        push_s;
   logic [rec_w_lp-1:0]         push_rec_s;
   logic                        err_set_s;
   logic                        posted_drop_s;
   logic                        full_s, empty_s, pop_s;
   logic                        wr_en_s, rd_adv_s, full_drop_s;
   logic [1:0]                  drop_inc_s;
   logic [16:0]                 drop_sum_s;
   logic [rec_w_lp-1:0]         head_s;

   // Next-state decode: capture, record push and protocol-violation detection
   always_comb begin
      state_n_s     = state_r;
      cap_s         = 1'b0;
      push_s        = 1'b0;
      push_rec_s    = '0;
      err_set_s     = 1'b0;
      posted_drop_s = 1'b0;
      if (freeze_i) begin
         // Pending capture is abandoned without a record
         state_n_s = e_idle;
      end else begin
         case (state_r)
            e_idle: begin
               if (req_complete_i) begin
                  err_set_s = 1'b1;
               end else begin
                  err_set_s = 1'b0;
               end
               if (req_v_i && !req_posted_i) begin
                  state_n_s = e_pending;
                  cap_s     = 1'b1;
               end else if (req_v_i && req_posted_i) begin
                  push_s     = 1'b1;
                  push_rec_s = {req_addr_i, req_msg_type_i, cycle_r, {latency_width_p{1'b0}}};
               end else begin
                  state_n_s = e_idle;
               end
            end
            e_pending: begin
               if (req_complete_i) begin
                  push_s     = 1'b1;
                  push_rec_s = {addr_r, type_r, start_r, lat_sat_inc(lat_r)};
                  if (req_v_i && !req_posted_i) begin
                     // Back-to-back blocking request: stay pending on the new one
                     cap_s     = 1'b1;
                     state_n_s = e_pending;
                  end else begin
                     state_n_s = e_idle;
                  end
                  // A posted record cannot share the single write port
                  posted_drop_s = req_v_i && req_posted_i;
               end else if (req_v_i && !req_posted_i) begin
                  err_set_s = 1'b1;
               end else if (req_v_i && req_posted_i) begin
                  push_s     = 1'b1;
                  push_rec_s = {req_addr_i, req_msg_type_i, cycle_r, {latency_width_p{1'b0}}};
               end else begin
                  state_n_s = e_pending;
               end
            end
            default: begin
               state_n_s = e_idle;
            end
         endcase
      end
   end

   assign empty_s = (wptr_r == rptr_r);
   assign full_s  = (wptr_r[idx_w_lp-1:0] == rptr_r[idx_w_lp-1:0]) &&
                    (wptr_r[idx_w_lp] != rptr_r[idx_w_lp]);
   assign pop_s   = !empty_s && evt_ready_i;

   // FIFO write/read pointer control for the full-FIFO policy
   always_comb begin
      wr_en_s     = 1'b0;
      rd_adv_s    = pop_s;
      full_drop_s = 1'b0;
      if (push_s && full_s && !pop_s) begin
`ifdef BP_CACHE_EVT_OVERWRITE_EN
         // Evict the oldest entry to make room for the new one
         wr_en_s     = 1'b1;
         rd_adv_s    = 1'b1;
         full_drop_s = 1'b1;
`else
         wr_en_s     = 1'b0;
         full_drop_s = 1'b1;
`endif
      end else begin
         wr_en_s = push_s;
      end
   end

   assign drop_inc_s = {1'b0, posted_drop_s} + {1'b0, full_drop_s};
   assign drop_sum_s = {1'b0, drop_r} + {15'b0, drop_inc_s};

   // Control state, counters, capture registers and FIFO pointers
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r       <= e_idle;
         cycle_r       <= '0;
         addr_r        <= '0;
         type_r        <= '0;
         start_r       <= '0;
         lat_r         <= '0;
         outstanding_r <= 1'b0;
         err_r         <= 1'b0;
         drop_r        <= 16'h0000;
         wptr_r        <= '0;
         rptr_r        <= '0;
      end else begin
         state_r       <= state_n_s;
         cycle_r       <= cycle_r + cycle_width_p'(1);
         outstanding_r <= (state_n_s == e_pending);
         err_r         <= err_r | err_set_s;
         drop_r        <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
         if (cap_s) begin
            addr_r  <= req_addr_i;
            type_r  <= req_msg_type_i;
            start_r <= cycle_r;
            lat_r   <= '0;
         end else if (state_r == e_pending) begin
            lat_r <= lat_sat_inc(lat_r);
         end else begin
            lat_r <= lat_r;
         end
         if (wr_en_s) begin
            wptr_r <= wptr_r + (idx_w_lp + 1)'(1);
         end
         if (rd_adv_s) begin
            rptr_r <= rptr_r + (idx_w_lp + 1)'(1);
         end
      end
   end

   // Record storage; pointers alone define validity so no reset is needed
   always_ff @(posedge clk_i) begin
      if (reset_n_i && wr_en_s) begin
         mem_r[wptr_r[idx_w_lp-1:0]] <= push_rec_s;
      end
   end

   assign head_s         = mem_r[rptr_r[idx_w_lp-1:0]];
   assign evt_v_o        = !empty_s;
   assign evt_addr_o     = head_s[rec_w_lp-1 -: paddr_width_p];
   assign evt_msg_type_o = head_s[cycle_width_p+latency_width_p +: msg_type_width_p];
   assign evt_start_o    = head_s[latency_width_p +: cycle_width_p];
   assign evt_latency_o  = head_s[latency_width_p-1:0];
   assign outstanding_o  = outstanding_r;
   assign drop_count_o   = drop_r;
   assign err_o          = err_r;

endmodule

// File: tb/tb_bp_cache_req_event_buffer.sv
module tb_bp_cache_req_event_buffer;

   typedef struct {
      logic [39:0] addr;
      logic [3:0]  mtype;
      logic [31:0] start;
      logic [15:0] lat;
   } rec_t;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        freeze_i;
   logic        req_v_i;
   logic [3:0]  req_msg_type_i;
   logic [39:0] req_addr_i;
   logic        req_posted_i;
   logic        req_complete_i;
   logic        evt_v_o;
   logic        evt_ready_i;
   logic [39:0] evt_addr_o;
   logic [3:0]  evt_msg_type_o;
   logic [31:0] evt_start_o;
   logic [15:0] evt_latency_o;
   logic        outstanding_o;
   logic [15:0] drop_count_o;
   logic        err_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] tb_cyc;
   rec_t        exp_q[$];

   bp_cache_req_event_buffer dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .freeze_i(freeze_i),
      .req_v_i(req_v_i), .req_msg_type_i(req_msg_type_i), .req_addr_i(req_addr_i),
      .req_posted_i(req_posted_i), .req_complete_i(req_complete_i),
      .evt_v_o(evt_v_o), .evt_ready_i(evt_ready_i), .evt_addr_o(evt_addr_o),
      .evt_msg_type_o(evt_msg_type_o), .evt_start_o(evt_start_o),
      .evt_latency_o(evt_latency_o), .outstanding_o(outstanding_o),
      .drop_count_o(drop_count_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference cycle counter: the cycle in which currently driven inputs are sampled
   always @(posedge clk_i) begin
      if (!reset_n_i) tb_cyc <= 32'd0;
      else            tb_cyc <= tb_cyc + 32'd1;
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      freeze_i = 1'b0; req_v_i = 1'b0; req_msg_type_i = 4'h0; req_addr_i = 40'h0;
      req_posted_i = 1'b0; req_complete_i = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n_i = 1'b0;
      step();
      step();
      reset_n_i = 1'b1;
      exp_q.delete();
   endtask

   task automatic wait_cyc(input logic [31:0] n);
      while (tb_cyc != n) step();
   endtask

   task automatic drive_req(input logic [39:0] a, input logic [3:0] t, input logic posted);
      req_v_i = 1'b1; req_addr_i = a; req_msg_type_i = t; req_posted_i = posted;
   endtask

   function automatic rec_t mk(input logic [39:0] a, input logic [3:0] t,
                               input logic [31:0] s, input logic [15:0] l);
      rec_t r;
      r.addr = a; r.mtype = t; r.start = s; r.lat = l;
      return r;
   endfunction

   logic [31:0] a_cyc, b_cyc;
   logic [31:0] fill_start [9];

   initial begin
      evt_ready_i = 1'b1;
      do_reset();

      fork
         // Monitor: every accepted record must match the oldest expected one
         begin
            rec_t e;
            forever begin
               @(negedge clk_i);
               if (reset_n_i && evt_v_o && evt_ready_i) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_rec actual addr=%0h start=%0d lat=%0d expected none",
                              evt_addr_o, evt_start_o, evt_latency_o);
                  end else begin
                     e = exp_q.pop_front();
                     chk("rec", {evt_addr_o[31:0], evt_msg_type_o, evt_start_o[11:0], evt_latency_o},
                         {e.addr[31:0], e.mtype, e.start[11:0], e.lat});
                  end
               end
            end
         end
      join_none

      // Reset state
      chk("rst_evt_v", {63'b0, evt_v_o}, 64'd0);
      chk("rst_outstanding", {63'b0, outstanding_o}, 64'd0);
      chk("rst_drop", {48'b0, drop_count_o}, 64'd0);
      chk("rst_err", {63'b0, err_o}, 64'd0);

      // Posted store at cycle 5
      wait_cyc(32'd5);
      drive_req(40'h1000, 4'h2, 1'b1);
      exp_q.push_back(mk(40'h1000, 4'h2, 32'd5, 16'd0));
      step();
      idle_inputs();
      chk("posted_visible", {63'b0, evt_v_o}, 64'd1);
      chk("posted_idle", {63'b0, outstanding_o}, 64'd0);

      // Blocking request at cycle 10, completion at 17
      wait_cyc(32'd10);
      drive_req(40'h80_0000_1040, 4'h1, 1'b0);
      exp_q.push_back(mk(40'h80_0000_1040, 4'h1, 32'd10, 16'd7));
      step();
      idle_inputs();
      for (int c = 11; c <= 17; c++) begin
         chk("blk_outstanding", {63'b0, outstanding_o}, 64'd1);
         chk("blk_no_early", {63'b0, evt_v_o}, 64'd0);
         if (c == 17) req_complete_i = 1'b1;
         step();
      end
      idle_inputs();
      chk("blk_rec_at_18", {63'b0, evt_v_o}, 64'd1);
      chk("blk_outstanding_lo", {63'b0, outstanding_o}, 64'd0);
      step();

      // Completion coinciding with a new blocking request
      a_cyc = tb_cyc;
      drive_req(40'h2000, 4'h3, 1'b0);
      step();
      idle_inputs();
      step();
      step();
      b_cyc = tb_cyc;
      req_complete_i = 1'b1;
      drive_req(40'h3000, 4'h5, 1'b0);
      exp_q.push_back(mk(40'h2000, 4'h3, a_cyc, 16'd3));
      step();
      idle_inputs();
      chk("b2b_outstanding", {63'b0, outstanding_o}, 64'd1);
      step();
      step();
      step();
      req_complete_i = 1'b1;
      exp_q.push_back(mk(40'h3000, 4'h5, b_cyc, 16'd4));
      step();
      idle_inputs();
      chk("b2b_done", {63'b0, outstanding_o}, 64'd0);
      chk("b2b_no_err", {63'b0, err_o}, 64'd0);

      // Posted request colliding with a completion is dropped
      a_cyc = tb_cyc;
      drive_req(40'h4000, 4'h6, 1'b0);
      step();
      req_complete_i = 1'b1;
      drive_req(40'h5000, 4'h7, 1'b1);
      exp_q.push_back(mk(40'h4000, 4'h6, a_cyc, 16'd1));
      step();
      idle_inputs();
      chk("coll_drop", {48'b0, drop_count_o}, 64'd1);
      step();
      step();

      // Completion in IDLE is a sticky error with no record
      req_complete_i = 1'b1;
      step();
      idle_inputs();
      chk("idle_cmpl_err", {63'b0, err_o}, 64'd1);
      chk("idle_cmpl_norec", {63'b0, evt_v_o}, 64'd0);
      step();
      step();
      chk("err_sticky", {63'b0, err_o}, 64'd1);
      do_reset();
      chk("rst2_err", {63'b0, err_o}, 64'd0);
      chk("rst2_drop", {48'b0, drop_count_o}, 64'd0);

      // Nine posted requests into an eight-deep FIFO with the sink stalled
      evt_ready_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         fill_start[i] = tb_cyc;
         drive_req(40'h100 + 40'(i), 4'(i), 1'b1);
`ifdef BP_CACHE_EVT_OVERWRITE_EN
         if (i == 8) void'(exp_q.pop_front());
         exp_q.push_back(mk(40'h100 + 40'(i), 4'(i), tb_cyc, 16'd0));
`else
         if (i < 8) exp_q.push_back(mk(40'h100 + 40'(i), 4'(i), tb_cyc, 16'd0));
`endif
         step();
      end
      idle_inputs();
      chk("fill_drop", {48'b0, drop_count_o}, 64'd1);
`ifdef BP_CACHE_EVT_OVERWRITE_EN
      chk("fill_head_addr", {24'b0, evt_addr_o}, 64'h101);
      chk("fill_head_start", {32'b0, evt_start_o}, {32'b0, fill_start[1]});
`else
      chk("fill_head_addr", {24'b0, evt_addr_o}, 64'h100);
      chk("fill_head_start", {32'b0, evt_start_o}, {32'b0, fill_start[0]});
`endif
      step();
      step();
`ifdef BP_CACHE_EVT_OVERWRITE_EN
      chk("fill_head_hold", {24'b0, evt_addr_o}, 64'h101);
`else
      chk("fill_head_hold", {24'b0, evt_addr_o}, 64'h100);
`endif
      evt_ready_i = 1'b1;
      repeat (10) step();
      chk("fill_drained", {63'b0, evt_v_o}, 64'd0);

      // Freeze abandons a pending capture; the later completion is an error
      do_reset();
      step();
      drive_req(40'h6000, 4'h8, 1'b0);
      step();
      idle_inputs();
      step();
      freeze_i = 1'b1;
      step();
      step();
      freeze_i = 1'b0;
      chk("freeze_idle", {63'b0, outstanding_o}, 64'd0);
      req_complete_i = 1'b1;
      step();
      idle_inputs();
      chk("freeze_err", {63'b0, err_o}, 64'd1);
      chk("freeze_norec", {63'b0, evt_v_o}, 64'd0);

      // Latency saturation after a long stall
      a_cyc = tb_cyc;
      drive_req(40'hABC0, 4'h9, 1'b0);
      exp_q.push_back(mk(40'hABC0, 4'h9, a_cyc, 16'hFFFF));
      step();
      idle_inputs();
      repeat (70000) step();
      req_complete_i = 1'b1;
      step();
      idle_inputs();
      chk("sat_rec_valid", {63'b0, evt_v_o}, 64'd1);
      repeat (5) step();

      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
